// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//   MEM stage of the 5-stage pipeline. Owns the EX/MEM register, drives the
//   data-memory request, aligns store data / byte enables, extends load data
//   and produces the MEM/WB register. Stalls the upstream pipe while the
//   memory has not signalled dmem_ready.
//
// Handshake: dmem_req is a level request taken combinationally from the
//   EX/MEM register. The access completes on the first cycle in which
//   dmem_req=1 and dmem_ready=1; address, we, be and wdata stay stable from
//   the first request cycle to the completion cycle. dmem_ready seen while
//   dmem_req=0 has no effect.
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   *_EXE_MEM                 EXE outputs captured into EX/MEM
//   dmem_*                    data-memory request/response
//   stall_MEM                 hold PC, IF/ID, ID/EX and EX/MEM
//   misalign_MEM              single-cycle flag: misaligned access dropped
//   *_EX_MEM                  EX/MEM fields for forwarding
//   *_MEM_WB                  MEM/WB register contents
//   state_dbg                 FSM state (0 = IDLE, 1 = WAIT)
// ---------------------------------------------------------------------------
module mem_access_stage #(
    parameter int DADDR_W = 13
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [31:0]        ALU_Result_EXE_MEM,
    input  logic [31:0]        write_data_EXE_MEM,
    input  logic [3:0]         MemRead_EXE_MEM,
    input  logic [3:0]         MemWrite_EXE_MEM,
    input  logic [1:0]         MemtoReg_EXE_MEM,
    input  logic               RegWrite_EXE_MEM,
    input  logic [4:0]         rd_EXE_MEM,
    input  logic [14:0]        pc_EXE_MEM,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [3:0]         dmem_be,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [31:0]        dmem_wdata,
    input  logic [31:0]        dmem_rdata,
    input  logic               dmem_ready,
    output logic               stall_MEM,
    output logic               misalign_MEM,
    output logic [31:0]        ALU_Result_EX_MEM,
    output logic [4:0]         rd_EX_MEM,
    output logic               RegWrite_EX_MEM,
    output logic [31:0]        read_data_MEM_WB,
    output logic [31:0]        ALU_Result_MEM_WB,
    output logic [1:0]         MemtoReg_MEM_WB,
    output logic               RegWrite_MEM_WB,
    output logic [4:0]         rd_MEM_WB,
    output logic [14:0]        pc_MEM_WB,
    output logic               state_dbg
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t state_q, state_d;

    // EX/MEM register
    logic [31:0] ex_alu;
    logic [31:0] ex_wdata;
    logic [3:0]  ex_rcode;
    logic [3:0]  ex_wcode;
    logic [1:0]  ex_mtr;
    logic        ex_rw;
    logic [4:0]  ex_rd;
    logic [14:0] ex_pc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_alu   <= '0;
            ex_wdata <= '0;
            ex_rcode <= '0;
            ex_wcode <= '0;
            ex_mtr   <= '0;
            ex_rw    <= 1'b0;
            ex_rd    <= '0;
            ex_pc    <= '0;
        end else if (!stall_MEM) begin
            ex_alu   <= ALU_Result_EXE_MEM;
            ex_wdata <= write_data_EXE_MEM;
            ex_rcode <= MemRead_EXE_MEM;
            ex_wcode <= MemWrite_EXE_MEM;
            ex_mtr   <= MemtoReg_EXE_MEM;
            ex_rw    <= RegWrite_EXE_MEM;
            ex_rd    <= rd_EXE_MEM;
            ex_pc    <= pc_EXE_MEM;
        end
    end

    assign ALU_Result_EX_MEM = ex_alu;
    assign rd_EX_MEM         = ex_rd;
    assign RegWrite_EX_MEM   = ex_rw;

    // Access decode. A non-zero store code takes priority and the load code
    // is then ignored entirely.
    logic [1:0] off;
    logic       is_store;
    logic       is_load;
    logic       misaligned;
    logic       access_valid;
    logic [3:0] size_mask;

    assign off = ex_alu[1:0];

    always_comb begin
        is_store   = 1'b0;
        is_load    = 1'b0;
        misaligned = 1'b0;
        size_mask  = 4'b0000;
        if (ex_wcode != 4'b0000) begin
            is_store = 1'b1;
            case (ex_wcode)
                4'b0001: size_mask = 4'b0001;
                4'b0011: begin size_mask = 4'b0011; misaligned = off[0]; end
                4'b1111: begin size_mask = 4'b1111; misaligned = |off;   end
                default: misaligned = 1'b1;
            endcase
        end else if (ex_rcode != 4'b0000) begin
            is_load = 1'b1;
            case (ex_rcode)
                4'b0001, 4'b0010: size_mask = 4'b0001;
                4'b0011, 4'b0100: begin size_mask = 4'b0011; misaligned = off[0]; end
                4'b1111:          begin size_mask = 4'b1111; misaligned = |off;   end
                default:          misaligned = 1'b1;
            endcase
        end
        access_valid = (is_store | is_load) & ~misaligned;
    end

    // misaligned can only be set when some code is present, and a dropped
    // access never stalls, so EX/MEM reloads next cycle: a single-cycle flag.
    assign misalign_MEM = misaligned;

    // Request FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        dmem_req  = 1'b0;
        stall_MEM = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access_valid) begin
                    dmem_req = 1'b1;
                    if (!dmem_ready) begin
                        stall_MEM = 1'b1;
                        state_d   = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // EX/MEM is frozen, so the access seen in IDLE is still there.
                dmem_req = 1'b1;
                if (dmem_ready) state_d   = ST_IDLE;
                else            stall_MEM = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign state_dbg = state_q;

    // Request payload
    assign dmem_we   = dmem_req & is_store;
    assign dmem_be   = dmem_req ? (size_mask << off) : 4'b0000;
    assign dmem_addr = ex_alu[DADDR_W+1:2];

    always_comb begin
        dmem_wdata = '0;
        if (is_store) begin
            case (ex_wcode)
                4'b0001: dmem_wdata = {4{ex_wdata[7:0]}};
                4'b0011: dmem_wdata = {2{ex_wdata[15:0]}};
                4'b1111: dmem_wdata = ex_wdata;
                default: dmem_wdata = '0;
            endcase
        end
    end

    // Load lane select and extension; zero for anything that is not a
    // completed, aligned load.
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    always_comb begin
        ld_byte = dmem_rdata[{off, 3'b000} +: 8];
        ld_half = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        ld_ext  = '0;
        if (is_load && access_valid) begin
            case (ex_rcode)
                4'b0001: ld_ext = {{24{ld_byte[7]}}, ld_byte};
                4'b0010: ld_ext = {24'b0, ld_byte};
                4'b0011: ld_ext = {{16{ld_half[15]}}, ld_half};
                4'b0100: ld_ext = {16'b0, ld_half};
                4'b1111: ld_ext = dmem_rdata;
                default: ld_ext = '0;
            endcase
        end
    end

    // MEM/WB register. A stall cycle writes a bubble: control cleared,
    // data fields left as they were.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_data_MEM_WB  <= '0;
            ALU_Result_MEM_WB <= '0;
            MemtoReg_MEM_WB   <= '0;
            RegWrite_MEM_WB   <= 1'b0;
            rd_MEM_WB         <= '0;
            pc_MEM_WB         <= '0;
        end else if (stall_MEM) begin
            MemtoReg_MEM_WB   <= '0;
            RegWrite_MEM_WB   <= 1'b0;
        end else begin
            read_data_MEM_WB  <= ld_ext;
            ALU_Result_MEM_WB <= ex_alu;
            MemtoReg_MEM_WB   <= ex_mtr;
            RegWrite_MEM_WB   <= ex_rw & ~misaligned;
            rd_MEM_WB         <= ex_rd;
            pc_MEM_WB         <= ex_pc;
        end
    end

endmodule
